// File: rtl/router_node_port.sv
// Router-side endpoint of the node/router byte-serial link: inbound deserializer + FWFT FIFO,
// outbound serializer. Optional packet counters under `ROUTER_NODE_PORT_STATS_EN`.
module router_node_port #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        free_outbound,
    input  logic        put_outbound,
    input  logic [7:0]  payload_outbound,
    input  logic        free_inbound,
    output logic        put_inbound,
    output logic [7:0]  payload_inbound,
    output logic [31:0] rx_pkt,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [31:0] tx_pkt,
    input  logic        tx_valid,
    output logic        tx_ready
`ifdef ROUTER_NODE_PORT_STATS_EN
    ,
    output logic [15:0] rx_pkt_count,
    output logic [15:0] tx_pkt_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic { RX_IDLE, RX_RECV } rx_state_t;
    typedef enum logic { TX_IDLE, TX_SEND } tx_state_t;

    rx_state_t      rx_state_q;
    logic [1:0]     rx_idx_q;
    logic [31:0]    shift_q;

    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    tx_state_t      tx_state_q;
    logic [1:0]     tx_idx_q;
    logic [31:0]    hold_q;

    logic           push;
    logic           pop;
    logic [31:0]    push_word;
    logic           tx_done;

    // A slot is reserved at packet start, so the push at byte 0 always has room.
    assign free_outbound = (rx_state_q == RX_IDLE) && (count_q < DEPTH_C) && !reset;
    assign push          = (rx_state_q == RX_RECV) && put_outbound && (rx_idx_q == 2'd0) && !reset;
    assign push_word     = {shift_q[31:8], payload_outbound};

    assign rx_valid = (count_q != '0) && !reset;
    assign rx_pkt   = mem_q[rd_ptr_q];
    assign pop      = rx_valid && rx_ready;

    assign tx_ready        = (tx_state_q == TX_IDLE) && !reset;
    assign put_inbound     = (tx_state_q == TX_SEND) && !reset;
    assign payload_inbound = put_inbound ? hold_q[8*tx_idx_q +: 8] : 8'h00;
    assign tx_done         = (tx_state_q == TX_SEND) && free_inbound && (tx_idx_q == 2'd0) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_idx_q   <= 2'd3;
            shift_q    <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (put_outbound && free_outbound) begin
                        shift_q[31:24] <= payload_outbound;
                        rx_idx_q       <= 2'd2;
                        rx_state_q     <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    if (put_outbound) begin
                        shift_q[8*rx_idx_q +: 8] <= payload_outbound;
                        if (rx_idx_q == 2'd0) begin
                            rx_idx_q   <= 2'd3;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_idx_q <= rx_idx_q - 2'd1;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_idx_q   <= 2'd3;
            hold_q     <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_valid) begin
                        hold_q     <= tx_pkt;
                        tx_idx_q   <= 2'd3;
                        tx_state_q <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (free_inbound) begin
                        if (tx_idx_q == 2'd0) begin
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_idx_q <= tx_idx_q - 2'd1;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

`ifdef ROUTER_NODE_PORT_STATS_EN
    logic [15:0] rx_cnt_q;
    logic [15:0] tx_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (push)    rx_cnt_q <= rx_cnt_q + 16'd1;
            if (tx_done) tx_cnt_q <= tx_cnt_q + 16'd1;
        end
    end

    assign rx_pkt_count = rx_cnt_q;
    assign tx_pkt_count = tx_cnt_q;
`else
    logic unused_tx_done;
    assign unused_tx_done = tx_done;
`endif

endmodule

// File: tb/tb_router_node_port.sv
// Directed self-checking bench for router_node_port (DEPTH = 4).
module tb_router_node_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        free_outbound;
    logic        put_outbound;
    logic [7:0]  payload_outbound;
    logic        free_inbound;
    logic        put_inbound;
    logic [7:0]  payload_inbound;
    logic [31:0] rx_pkt;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_pkt;
    logic        tx_valid;
    logic        tx_ready;
`ifdef ROUTER_NODE_PORT_STATS_EN
    logic [15:0] rx_pkt_count;
    logic [15:0] tx_pkt_count;
`endif

    int errors = 0;
    int checks = 0;
    int put_cycles;

    router_node_port #(.DEPTH(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .free_inbound     (free_inbound),
        .put_inbound      (put_inbound),
        .payload_inbound  (payload_inbound),
        .rx_pkt           (rx_pkt),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_pkt           (tx_pkt),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready)
`ifdef ROUTER_NODE_PORT_STATS_EN
        ,
        .rx_pkt_count     (rx_pkt_count),
        .tx_pkt_count     (tx_pkt_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            put_outbound     = 1'b1;
            payload_outbound = w[8*(3-i) +: 8];
            tick();
        end
        put_outbound = 1'b0;
    endtask

    task automatic send_tx(input logic [31:0] w);
        tx_pkt   = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tx_byte", {24'h0, payload_inbound}, {24'h0, w[8*(3-i) +: 8]});
            tick();
        end
        check("tx_idle_after", {31'h0, put_inbound}, 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        put_outbound     = 1'b0;
        payload_outbound = 8'h00;
        free_inbound     = 1'b1;
        rx_ready         = 1'b0;
        tx_pkt           = '0;
        tx_valid         = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_free_outbound", {31'h0, free_outbound}, 32'd0);
        check("rst_put_inbound",   {31'h0, put_inbound},   32'd0);
        check("rst_rx_valid",      {31'h0, rx_valid},      32'd0);
        check("rst_tx_ready",      {31'h0, tx_ready},      32'd0);
        check("rst_payload",       {24'h0, payload_inbound}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_free", {31'h0, free_outbound}, 32'd1);
        check("post_rst_txrdy", {31'h0, tx_ready}, 32'd1);

        // Single inbound packet
        put_outbound = 1'b1; payload_outbound = 8'hDE; tick();
        check("in_free_b2", {31'h0, free_outbound}, 32'd0);
        payload_outbound = 8'hAD; tick();
        check("in_free_b3", {31'h0, free_outbound}, 32'd0);
        payload_outbound = 8'hBE; tick();
        check("in_free_b4", {31'h0, free_outbound}, 32'd0);
        check("in_novalid_early", {31'h0, rx_valid}, 32'd0);
        payload_outbound = 8'hEF; tick();
        put_outbound = 1'b0;
        check("in_rx_valid", {31'h0, rx_valid}, 32'd1);
        check("in_rx_pkt", rx_pkt, 32'hDEADBEEF);
        check("in_free_after", {31'h0, free_outbound}, 32'd1);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        check("in_popped", {31'h0, rx_valid}, 32'd0);

        // Fill the FIFO, then a byte offered while full must be ignored
        send_pkt(32'h1111_1111);
        send_pkt(32'h2222_2222);
        send_pkt(32'h3333_3333);
        send_pkt(32'h4444_4444);
        check("full_free", {31'h0, free_outbound}, 32'd0);
        check("full_head", rx_pkt, 32'h1111_1111);
        put_outbound = 1'b1; payload_outbound = 8'h99; tick(); put_outbound = 1'b0;
        check("full_still", {31'h0, free_outbound}, 32'd0);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        check("pop1_free", {31'h0, free_outbound}, 32'd1);
        check("pop1_head", rx_pkt, 32'h2222_2222);
        rx_ready = 1'b1;
        tick(); check("pop2_head", rx_pkt, 32'h3333_3333);
        tick(); check("pop3_head", rx_pkt, 32'h4444_4444);
        tick(); check("drained", {31'h0, rx_valid}, 32'd0);
        rx_ready = 1'b0;

        // Outbound with a one-cycle free_inbound hold on the second byte
        put_cycles = 0;
        tx_pkt = 32'h1234_5678; tx_valid = 1'b1; free_inbound = 1'b1;
        tick(); tx_valid = 1'b0;
        check("tx_b0", {24'h0, payload_inbound}, 32'h12);
        check("tx_busy", {31'h0, tx_ready}, 32'd0);
        if (put_inbound) put_cycles++;
        tick();
        check("tx_b1", {24'h0, payload_inbound}, 32'h34);
        if (put_inbound) put_cycles++;
        free_inbound = 1'b0; tick();
        check("tx_b1_hold", {24'h0, payload_inbound}, 32'h34);
        if (put_inbound) put_cycles++;
        free_inbound = 1'b1; tick();
        check("tx_b2", {24'h0, payload_inbound}, 32'h56);
        if (put_inbound) put_cycles++;
        tick();
        check("tx_b3", {24'h0, payload_inbound}, 32'h78);
        if (put_inbound) put_cycles++;
        tick();
        if (put_inbound) put_cycles++;
        check("tx_idle_payload", {24'h0, payload_inbound}, 32'h00);
        check("tx_idle_ready", {31'h0, tx_ready}, 32'd1);
        check("tx_put_cycles", put_cycles, 32'd5);

        // Simultaneous inbound/outbound, then push+pop on the same edge at count 2
        send_pkt(32'hCAFE_F00D);
        tx_pkt = 32'h0102_0304; tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put_outbound = 1'b1;
            payload_outbound = (i < 2) ? 8'hA5 : 8'h0F;
            tick();
            tx_valid = 1'b0;
            check("sim_tx_byte", {24'h0, payload_inbound}, i + 1);
        end
        put_outbound = 1'b0;
        tick();
        check("sim_tx_done", {31'h0, put_inbound}, 32'd0);
        check("sim_head", rx_pkt, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) begin
            put_outbound = 1'b1;
            payload_outbound = 8'h0B + 8'(i);
            rx_ready = (i == 3);
            tick();
        end
        put_outbound = 1'b0;
        check("pp_head", rx_pkt, 32'hA5A5_0F0F);
        check("pp_free", {31'h0, free_outbound}, 32'd1);
        tick();
        check("pp_head2", rx_pkt, 32'h0B0C_0D0E);
        check("pp_valid2", {31'h0, rx_valid}, 32'd1);
        tick();
        check("pp_empty", {31'h0, rx_valid}, 32'd0);
        rx_ready = 1'b0;

        // Reset mid-packet on both paths with a packet already buffered
        send_pkt(32'h1357_9BDF);
        tx_pkt = 32'hDEAD_C0DE; tx_valid = 1'b1;
        put_outbound = 1'b1; payload_outbound = 8'h77; tick();
        tx_valid = 1'b0;
        payload_outbound = 8'h88; tick();
        put_outbound = 1'b0;
        check("pre_rst_tx", {24'h0, payload_inbound}, 32'hAD);
        reset = 1'b1; tick();
        check("mrst_put", {31'h0, put_inbound}, 32'd0);
        check("mrst_valid", {31'h0, rx_valid}, 32'd0);
        check("mrst_free", {31'h0, free_outbound}, 32'd0);
        reset = 1'b0; #1;
        check("mrst_free_after", {31'h0, free_outbound}, 32'd1);
        check("mrst_discard", {31'h0, rx_valid}, 32'd0);
        check("mrst_put_after", {31'h0, put_inbound}, 32'd0);
        send_pkt(32'hFEED_FACE);
        check("fresh_valid", {31'h0, rx_valid}, 32'd1);
        check("fresh_pkt", rx_pkt, 32'hFEED_FACE);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;

`ifdef ROUTER_NODE_PORT_STATS_EN
        send_pkt(32'hAAAA_0001);
        send_pkt(32'hAAAA_0002);
        send_tx(32'h5566_7788);
        send_tx(32'h99AA_BBCC);
        check("stat_rx", {16'h0, rx_pkt_count}, 32'd3);
        check("stat_tx", {16'h0, tx_pkt_count}, 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("stat_rx_rst", {16'h0, rx_pkt_count}, 32'd0);
        check("stat_tx_rst", {16'h0, tx_pkt_count}, 32'd0);
`else
        send_tx(32'h5566_7788);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_node_port.md
Name: router_node_port

Overview:
- Router-side endpoint of the node/router byte-serial link. It is the opposite end of the node's transmit and receive paths.
- Inbound path (node to router): deserializes 4-byte packets arriving on put_outbound/payload_outbound, MSB byte first. Completed 32-bit packets are buffered in a DEPTH-packet FIFO and presented to the router fabric over a valid/ready interface.
- Outbound path (router to node): accepts 32-bit packets from the fabric and serializes them to the node on put_inbound/payload_inbound. It honours the node's free_inbound flow control.

Parameters:
- DEPTH, 4, number of 32-bit packets held in the inbound FIFO. Must be a power of 2 and at least 2.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- free_outbound  output  1  router can accept a complete packet from the node.
- put_outbound  input  1  node is driving a valid byte this cycle.
- payload_outbound  input  8  byte from the node.
- free_inbound  input  1  node can accept a byte this cycle.
- put_inbound  output  1  router is driving a valid byte to the node.
- payload_inbound  output  8  byte to the node.
- rx_pkt  output  32  head of the inbound FIFO (first-word fall-through).
- rx_valid  output  1  inbound FIFO is non-empty.
- rx_ready  input  1  fabric pops the FIFO head when rx_valid is also high.
- tx_pkt  input  32  packet from the fabric for the node.
- tx_valid  input  1  tx_pkt is valid.
- tx_ready  output  1  the port accepts tx_pkt this cycle.

Behaviour:
- Reset: the sampled-high edge clears both FSMs, the FIFO pointers, the count and the byte indices.
  - While reset is high, free_outbound, put_inbound, rx_valid and tx_ready are 0, and payload_inbound is 8'h00.
  - A reset asserted mid-packet discards the partial packet and the entire FIFO contents.
- Inbound FSM, states RX_IDLE and RX_RECV; rx_idx is 2 bits and resets to 3.
  - free_outbound = (state == RX_IDLE) && (count < DEPTH) && !reset, decoded from registers only.
  - RX_IDLE: on put_outbound = 1 with free_outbound = 1, capture the byte into shift[3], set rx_idx to 2, go to RX_RECV.
  - RX_IDLE: put_outbound = 1 while free_outbound = 0 is a protocol violation; the byte is ignored.
  - RX_RECV: each cycle with put_outbound = 1, shift[rx_idx] <= payload_outbound and rx_idx decrements.
  - RX_RECV: a cycle with put_outbound = 0 holds all state, with no timeout.
  - RX_RECV: on capture of byte index 0, the assembled word {b3,b2,b1,b0} is pushed into the FIFO on that same edge, rx_idx returns to 3, and the FSM returns to RX_IDLE.
  - A FIFO slot is reserved at packet start because free_outbound requires space. A push is therefore never lost, and the fabric only ever frees slots.
  - Back-to-back: the next packet may start on the cycle after the push if count < DEPTH.
- FIFO:
  - First-word fall-through; rx_pkt is valid in the same cycle rx_valid = 1.
  - Pop occurs on rx_valid && rx_ready.
  - Push and pop on the same edge leave count unchanged and take effect together. This includes the DEPTH = full case and the count = 1 case.
  - Pointers are log2(DEPTH) bits wide and wrap naturally; count is log2(DEPTH)+1 bits wide.
  - Latency from the last inbound byte to rx_valid is 1 cycle.
- Outbound FSM, states TX_IDLE and TX_SEND; tx_idx is 2 bits.
  - tx_ready = (state == TX_IDLE) && !reset.
  - TX_IDLE: on tx_valid && tx_ready, latch tx_pkt into the hold register, set tx_idx to 3, go to TX_SEND.
  - TX_SEND: put_inbound = 1 and payload_inbound = hold[8*tx_idx +: 8].
  - A byte is consumed on each edge where free_inbound = 1; tx_idx then decrements.
  - When free_inbound = 0, the byte and tx_idx are held.
  - When byte 0 is consumed, return to TX_IDLE.
  - TX_IDLE: put_inbound = 0 and payload_inbound = 8'h00.
  - put_inbound first rises in the cycle after acceptance. Minimum spacing is 5 cycles per packet.
  - The node's one-cycle free_inbound drop after each packet is absorbed by the hold rule.
- The inbound and outbound paths are fully independent, and simultaneous activity on both is legal.

Optional Feature:
- Macro: ROUTER_NODE_PORT_STATS_EN.
- When defined, two extra output ports are compiled in:
  - rx_pkt_count [15:0] increments on each FIFO push.
  - tx_pkt_count [15:0] increments on each completed outbound packet, i.e. when byte 0 is consumed.
  - Both counters reset to 0 and wrap from 16'hFFFF to 16'h0000.
- When the macro is undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Inbound: put_outbound high for 4 cycles with bytes 8'hDE, 8'hAD, 8'hBE, 8'hEF -> rx_pkt = 32'hDEADBEEF and rx_valid = 1 one cycle after the last byte; free_outbound is 0 during bytes 2-4.
- Inbound with rx_ready held 0 and DEPTH=4: send 4 packets -> free_outbound stays 0 afterwards. One pop with rx_ready = 1 -> free_outbound = 1 the next cycle. Packets pop in order.
- Outbound: tx_pkt = 32'h12345678 -> payload_inbound sequence 8'h12, 8'h34, 8'h56, 8'h78. With free_inbound low on the second byte's cycle, 8'h34 is held for 2 cycles and put_inbound is high for 5 cycles total.
- Simultaneous: inbound packet 32'hA5A5_0F0F and outbound packet 32'h0102_0304 in overlapping cycles -> both arrive intact. A push and a pop on the same edge at count = 2 leave count = 2.
- Reset: assert reset after 2 inbound bytes and mid outbound send -> the next cycle has put_inbound = 0, rx_valid = 0 and free_outbound = 0, then free_outbound = 1 the cycle after reset deasserts. A fresh packet is received correctly.
- With ROUTER_NODE_PORT_STATS_EN defined: 3 inbound and 2 outbound packets -> rx_pkt_count = 3 and tx_pkt_count = 2; reset returns both counters to 0.
